stage2_window_gen: RTL and testbench

STAGE2_WINDOW_GEN -- requirements
Module: stage2_window_gen

---
 rtl/stage2_window_gen.sv | 157 +++++++++++++++
 tb/tb_stage2_window_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage2_window_gen.sv
// Sliding-window generator: turns a raster pixel stream into KY x KX windows.
// A window is emitted one cycle after each pixel that completes one. After each
// window the input is throttled for GAP-1 cycles to match the downstream kernel.
module stage2_window_gen #(
  parameter int IMG_W = 12,
  parameter int IMG_H = 12,
  parameter int KX    = 5,
  parameter int KY    = 5,
  parameter int DBW   = 20,
  parameter int GAP   = 28
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clear,
  input  logic                       i_in_valid,
  input  logic [DBW-1:0]             i_in_pixel,
  output logic                       o_in_ready,
  output logic                       o_ot_valid,
  output logic [KX*KY*DBW-1:0]       o_ot_fmap,
  output logic [$clog2(IMG_H)-1:0]   o_win_row,
  output logic [$clog2(IMG_W)-1:0]   o_win_col,
  output logic                       o_frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int TW = $clog2(GAP) + 1;
  localparam int FW = KX * KY * DBW;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KY - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KX - 1);
  localparam logic [TW-1:0] THR_LOAD = TW'(GAP - 1);

  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [TW-1:0]  thr_q, thr_d;
  logic [DBW-1:0] lb_q  [0:KY-2][0:IMG_W-1];
  logic [DBW-1:0] lb_d  [0:KY-2][0:IMG_W-1];
  logic [DBW-1:0] win_q [0:KY-1][0:KX-1];
  logic [DBW-1:0] win_d [0:KY-1][0:KX-1];
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic [FW-1:0]  fmap_q, fmap_d;
  logic [RW-1:0]  win_row_q, win_row_d;
  logic [CW-1:0]  win_col_q, win_col_d;
  logic           accept;
  logic           produce;

  // Accept/produce qualification; clear wins over any accept in the same cycle.
  always_comb begin
    accept  = i_in_valid && o_in_ready && !i_clear;
    produce = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
  end

  // Raster position counters and the post-window throttle down-counter.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    thr_d = thr_q;
    if (i_clear) begin
      row_d = '0;
      col_d = '0;
      thr_d = '0;
    end else begin
      if (accept) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      if (produce) begin
        thr_d = THR_LOAD;
      end else if (thr_q != '0) begin
        thr_d = thr_q - TW'(1);
      end
    end
  end

  // Line buffers shift one row up per column; the window shifts left and takes
  // the new column (oldest row on top, incoming pixel at the bottom).
  always_comb begin
    lb_d  = lb_q;
    win_d = win_q;
    if (accept) begin
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX - 1; x++) begin
          win_d[y][x] = win_q[y][x+1];
        end
      end
      for (int y = 0; y < KY - 1; y++) begin
        win_d[y][KX-1] = lb_q[y][col_q];
      end
      win_d[KY-1][KX-1] = i_in_pixel;
      for (int k = 0; k < KY - 2; k++) begin
        lb_d[k][col_q] = lb_q[k+1][col_q];
      end
      lb_d[KY-2][col_q] = i_in_pixel;
    end
  end

  // Output capture: outputs only change on a producing accept and hold otherwise.
  always_comb begin
    valid_d   = produce;
    done_d    = produce && (row_q == ROW_LAST) && (col_q == COL_LAST);
    fmap_d    = fmap_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    if (produce) begin
      win_row_d = row_q - ROW_WIN;
      win_col_d = col_q - COL_WIN;
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX; x++) begin
          fmap_d[(y*KX+x)*DBW +: DBW] = win_d[y][x];
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= '0;
      col_q     <= '0;
      thr_q     <= '0;
      lb_q      <= '{default: '0};
      win_q     <= '{default: '0};
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      fmap_q    <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      thr_q     <= thr_d;
      lb_q      <= lb_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      fmap_q    <= fmap_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  assign o_in_ready   = (thr_q == '0);
  assign o_ot_valid   = valid_q;
  assign o_frame_done = done_q;
  assign o_ot_fmap    = fmap_q;
  assign o_win_row    = win_row_q;
  assign o_win_col    = win_col_q;

endmodule

// File: tb/tb_stage2_window_gen.sv
// Scoreboard bench for stage2_window_gen: the driver pushes the expected window
// for every producing accept; a negedge monitor pops and compares on o_ot_valid.
module tb_stage2_window_gen;

  localparam int IMG_W = 12;
  localparam int IMG_H = 12;
  localparam int KX    = 5;
  localparam int KY    = 5;
  localparam int DBW   = 20;
  localparam int GAP   = 28;
  localparam int FW    = KX * KY * DBW;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     i_clear = 1'b0;
  logic                     i_in_valid = 1'b0;
  logic [DBW-1:0]           i_in_pixel = '0;
  logic                     o_in_ready;
  logic                     o_ot_valid;
  logic [FW-1:0]            o_ot_fmap;
  logic [$clog2(IMG_H)-1:0] o_win_row;
  logic [$clog2(IMG_W)-1:0] o_win_col;
  logic                     o_frame_done;

  stage2_window_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .KX(KX), .KY(KY), .DBW(DBW), .GAP(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_in_valid(i_in_valid),
    .i_in_pixel(i_in_pixel), .o_in_ready(o_in_ready), .o_ot_valid(o_ot_valid),
    .o_ot_fmap(o_ot_fmap), .o_win_row(o_win_row), .o_win_col(o_win_col),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] fmap;
    int            row;
    int            col;
    logic          done;
    int            acc;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] log_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int strobes = 0;
  int dones = 0;
  bit chk_gap = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [FW-1:0] got, logic [FW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic logic [DBW-1:0] pix(int mode, int r, int c);
    case (mode)
      0:       return DBW'(r * 16 + c);
      1:       return (r == 4 && c == 4) ? '1 : '0;
      default: return DBW'(r * 16 + c + 'h300);
    endcase
  endfunction

  function automatic logic [FW-1:0] exp_win(int mode, int r0, int c0);
    logic [FW-1:0] f;
    f = '0;
    for (int y = 0; y < KY; y++)
      for (int x = 0; x < KX; x++)
        f[(y*KX+x)*DBW +: DBW] = pix(mode, r0 + y, c0 + x);
    return f;
  endfunction

  function automatic logic [DBW-1:0] elem(logic [FW-1:0] f, int y, int x);
    return f[(y*KX+x)*DBW +: DBW];
  endfunction

  // Monitor: scoreboard pop, latency, strobe spacing, throttle length, hold.
  int            low_cnt = 0;
  bit            have_prev = 0;
  int            prev_row = 0;
  int            prev_cyc = 0;
  bit            prev_rst = 0;
  logic [FW-1:0] prev_fmap = '0;
  logic [7:0]    prev_rc = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      have_prev = 0;
      prev_rst  = 0;
    end else begin
      if (i_clear) have_prev = 0;
      if (o_ot_valid) begin
        strobes++;
        if (o_frame_done) dones++;
        log_q.push_back(o_ot_fmap);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_strobe row=%0d col=%0d (t=%0t)", o_win_row, o_win_col, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("win_fmap", o_ot_fmap, e.fmap);
          chk("win_row", FW'(o_win_row), FW'(e.row));
          chk("win_col", FW'(o_win_col), FW'(e.col));
          chk("frame_done", FW'(o_frame_done), FW'(e.done));
          chk("strobe_latency", FW'(cyc), FW'(e.acc + 1));
          if (have_prev && chk_gap)
            chk("ready_low_cycles", FW'(low_cnt), FW'(GAP - 1));
          if (have_prev && chk_gap && e.row == prev_row && e.col != 0)
            chk("strobe_spacing", FW'(cyc - prev_cyc), FW'(GAP));
          have_prev = 1;
          prev_row  = e.row;
          prev_cyc  = cyc;
        end
        low_cnt = 0;
      end else begin
        chk("done_without_valid", FW'(o_frame_done), FW'(0));
        if (prev_rst) begin
          chk("hold_fmap", o_ot_fmap, prev_fmap);
          chk("hold_rowcol", FW'({o_win_row, o_win_col}), FW'(prev_rc));
        end
      end
      if (!o_in_ready) low_cnt++;
      prev_fmap = o_ot_fmap;
      prev_rc   = {o_win_row, o_win_col};
      prev_rst  = 1;
    end
  end

  task automatic send_pix(int mode, int r, int c);
    int n;
    exp_t e;
    n = 0;
    i_in_valid = 1'b1;
    i_in_pixel = pix(mode, r, c);
    @(negedge clk);
    while (!o_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", FW'(o_in_ready), FW'(1));
    if (o_in_ready && r >= KY - 1 && c >= KX - 1) begin
      e.fmap = exp_win(mode, r - (KY - 1), c - (KX - 1));
      e.row  = r - (KY - 1);
      e.col  = c - (KX - 1);
      e.done = (r == IMG_H - 1 && c == IMG_W - 1);
      e.acc  = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    i_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Streams a frame in raster order; stops before (stop_r, stop_c) if given.
  task automatic send_frame(int mode, bit gapped, int stop_r, int stop_c);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r == stop_r && c == stop_c) begin
          i_in_valid = 1'b0;
          return;
        end
        send_pix(mode, r, c);
        if (gapped) idle($urandom_range(0, 3));
      end
    end
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", FW'(exp_q.size()), FW'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", FW'(o_ot_valid), FW'(0));
    chk("rst_done", FW'(o_frame_done), FW'(0));
    chk("rst_fmap", o_ot_fmap, FW'(0));
    chk("rst_row", FW'(o_win_row), FW'(0));
    chk("rst_col", FW'(o_win_col), FW'(0));
    chk("rst_ready", FW'(o_in_ready), FW'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [FW-1:0] f;
    logic [FW-1:0] mask;

    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_vals();
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Two back-to-back continuous frames.
    chk_gap = 1;
    send_frame(0, 0, -1, -1);
    send_frame(0, 0, -1, -1);
    drain();
    chk("windows_two_frames", FW'(strobes), FW'(128));
    chk("done_two_frames", FW'(dones), FW'(2));
    f = log_q[0];
    chk("first_e00", FW'(elem(f, 0, 0)), FW'('h00));
    chk("first_e04", FW'(elem(f, 0, 4)), FW'('h04));
    chk("first_e40", FW'(elem(f, 4, 0)), FW'('h40));
    chk("first_e44", FW'(elem(f, 4, 4)), FW'('h44));
    chk("last_e44", FW'(elem(log_q[63], 4, 4)), FW'('hBB));
    for (int i = 0; i < 64; i += 9) chk("frame2_eq_frame1", log_q[64 + i], log_q[i]);

    // Sign pass-through: only pixel (4,4) is -1.
    do_clear();
    send_frame(1, 0, 4, 5);
    drain();
    f = log_q[log_q.size() - 1];
    chk("sign_e44", FW'(elem(f, 4, 4)), FW'(20'hFFFFF));
    mask = '0;
    mask[24*DBW +: DBW] = '1;
    chk("sign_others_zero", f & ~mask, FW'(0));

    // Clear presented together with pixel (6,3), then a fresh frame.
    do_clear();
    send_frame(0, 0, 6, 3);
    drain();
    i_in_valid = 1'b1;
    i_in_pixel = pix(0, 6, 3);
    do_clear();
    base = log_q.size();
    send_frame(2, 0, -1, -1);
    drain();
    chk("clear_first_e00", FW'(elem(log_q[base], 0, 0)), FW'('h300));
    chk("clear_first_e44", FW'(elem(log_q[base], 4, 4)), FW'('h344));

    // Reset held low for two cycles at pixel (6,3), then a fresh frame.
    do_clear();
    send_frame(0, 0, 6, 3);
    drain();
    i_in_valid = 1'b1;
    i_in_pixel = pix(0, 6, 3);
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_vals();
    end
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    i_in_valid = 1'b0;
    @(posedge clk);
    #1;
    base = log_q.size();
    send_frame(2, 0, -1, -1);
    drain();
    chk("reset_first_e00", FW'(elem(log_q[base], 0, 0)), FW'('h300));
    chk("reset_first_e44", FW'(elem(log_q[base], 4, 4)), FW'('h344));

    // Gapped input must reproduce the continuous frame exactly.
    do_clear();
    base = log_q.size();
    send_frame(0, 1, -1, -1);
    drain();
    for (int i = 0; i < 64; i += 7) chk("gapped_eq_cont", log_q[base + i], log_q[i]);

    chk("total_windows", FW'(strobes), FW'(128 + 1 + 16 + 64 + 16 + 64 + 64));
    chk("total_frame_done", FW'(dones), FW'(5));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
